event_neighbor_scan: RTL and testbench

- Upstream of dpos_quant in the graph-conv datapath. Keeps a circular history of the last DEPTH events.
- For each accepted event, scans the history and streams one (new, neighbour) pair per matching entry. A match is a Chebyshev distance within RADIUS.
- Pair outputs connect directly to dpos_quant inputs (new_x/neighbor_x/new_y/neighbor_y/new_p/neighbor_p/in_valid).
- After the scan, the new event is written into the history, overwriting the oldest entry.

---
 rtl/event_neighbor_scan_pkg.sv | 28 ++
 rtl/event_neighbor_scan_match.sv | 24 ++
 rtl/event_neighbor_scan.sv | 162 ++++++++++++++++
 tb/tb_event_neighbor_scan.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/event_neighbor_scan_pkg.sv
// Shared types for the graph-conv event front end: pixel index types,
// neighbour-scan defaults, scan FSM states and an unsigned distance helper.
package event_neighbor_scan_pkg;

  localparam int X_PIXEL_WIDTH = 8;
  localparam int Y_PIXEL_WIDTH = 8;

  typedef logic [X_PIXEL_WIDTH-1:0] x_idx_t;
  typedef logic [Y_PIXEL_WIDTH-1:0] y_idx_t;

  localparam int NB_DEPTH  = 16;
  localparam int NB_RADIUS = 3;

  // Wide enough for either coordinate plus one bit, so differences never wrap.
  localparam int DIFF_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    INSERT = 2'd2
  } scan_state_t;

  function automatic logic [DIFF_W-1:0] diff_abs(input logic [DIFF_W-1:0] a,
                                                  input logic [DIFF_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/event_neighbor_scan_match.sv
// Combinational neighbour test: a valid history entry matches when both
// coordinate distances to the latched event are within RADIUS.
module nb_match
  import event_neighbor_scan_pkg::*;
#(
  parameter int RADIUS = NB_RADIUS
) (
  input  logic   entry_valid,
  input  x_idx_t entry_x,
  input  y_idx_t entry_y,
  input  x_idx_t ev_x,
  input  y_idx_t ev_y,
  output logic   match
);

  logic [DIFF_W-1:0] dx;
  logic [DIFF_W-1:0] dy;

  assign dx = diff_abs(DIFF_W'(ev_x), DIFF_W'(entry_x));
  assign dy = diff_abs(DIFF_W'(ev_y), DIFF_W'(entry_y));

  assign match = entry_valid && (dx <= DIFF_W'(RADIUS)) && (dy <= DIFF_W'(RADIUS));

endmodule

// File: rtl/event_neighbor_scan.sv
// Circular event history with a one-entry-per-cycle neighbour scan; streams
// (new, neighbour) pairs into dpos_quant, then inserts the new event.
//
// state  | meaning
// IDLE   | waiting for an event; flush clears the history here
// SCAN   | testing history entry idx against the latched event
// INSERT | writing the latched event at wr_ptr; done follows next cycle
module event_neighbor_scan
  import event_neighbor_scan_pkg::*;
#(
  parameter int DEPTH  = NB_DEPTH,
  parameter int RADIUS = NB_RADIUS,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  x_idx_t           ev_x,
  input  y_idx_t           ev_y,
  input  logic             ev_p,
  input  logic             ev_valid,
  output logic             ev_ready,
  input  logic             flush,
  output x_idx_t           new_x,
  output y_idx_t           new_y,
  output logic             new_p,
  output x_idx_t           neighbor_x,
  output y_idx_t           neighbor_y,
  output logic             neighbor_p,
  output logic             pair_valid,
  output logic             done,
  output logic [CNT_W-1:0] nb_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  scan_state_t state;
  scan_state_t state_nxt;

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  x_idx_t lat_x;
  y_idx_t lat_y;
  logic   lat_p;

  x_idx_t           hist_x [DEPTH];
  y_idx_t           hist_y [DEPTH];
  logic             hist_p [DEPTH];
  logic [DEPTH-1:0] hist_v;

  logic hit;
  logic last_idx;

  nb_match #(
    .RADIUS(RADIUS)
  ) u_match (
    .entry_valid(hist_v[idx]),
    .entry_x    (hist_x[idx]),
    .entry_y    (hist_y[idx]),
    .ev_x       (lat_x),
    .ev_y       (lat_y),
    .match      (hit)
  );

  assign last_idx = (idx == IDX_W'(DEPTH - 1));

  always_comb begin
    state_nxt = state;
    ev_ready  = 1'b0;
    unique case (state)
      IDLE: begin
        ev_ready = !flush;
        if (ev_valid && !flush) state_nxt = SCAN;
      end
      SCAN: begin
        if (last_idx) state_nxt = INSERT;
      end
      INSERT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      hist_v     <= '0;
      wr_ptr     <= '0;
      idx        <= '0;
      count      <= '0;
      lat_x      <= '0;
      lat_y      <= '0;
      lat_p      <= 1'b0;
      pair_valid <= 1'b0;
      done       <= 1'b0;
      nb_count   <= '0;
      new_x      <= '0;
      new_y      <= '0;
      new_p      <= 1'b0;
      neighbor_x <= '0;
      neighbor_y <= '0;
      neighbor_p <= 1'b0;
    end else begin
      pair_valid <= 1'b0;
      done       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (flush) begin
            hist_v <= '0;
            wr_ptr <= '0;
          end else if (ev_valid) begin
            lat_x <= ev_x;
            lat_y <= ev_y;
            lat_p <= ev_p;
            idx   <= '0;
            count <= '0;
          end
        end
        SCAN: begin
          // Pair fields are only loaded on a match, so they hold otherwise.
          if (hit) begin
            pair_valid <= 1'b1;
            new_x      <= lat_x;
            new_y      <= lat_y;
            new_p      <= lat_p;
            neighbor_x <= hist_x[idx];
            neighbor_y <= hist_y[idx];
            neighbor_p <= hist_p[idx];
            count      <= count + CNT_W'(1);
          end
          idx <= idx + IDX_W'(1);
        end
        INSERT: begin
          hist_v[wr_ptr] <= 1'b1;
          wr_ptr         <= wr_ptr + IDX_W'(1);
          done           <= 1'b1;
          nb_count       <= count;
        end
        default: begin
        end
      endcase
    end
  end

  // Payload storage needs no reset: entries are qualified by hist_v.
  always_ff @(posedge clk) begin
    if (rstn && (state == INSERT)) begin
      hist_x[wr_ptr] <= lat_x;
      hist_y[wr_ptr] <= lat_y;
      hist_p[wr_ptr] <= lat_p;
    end
  end

endmodule

// File: tb/tb_event_neighbor_scan.sv
// Self-checking bench for event_neighbor_scan: randomized and directed events
// compared against an array-based history model.
module tb_event_neighbor_scan;
  import event_neighbor_scan_pkg::*;

  localparam int DEPTH  = 16;
  localparam int RADIUS = 3;
  localparam int CNT_W  = 5;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  x_idx_t           ev_x = '0;
  y_idx_t           ev_y = '0;
  logic             ev_p = 1'b0;
  logic             ev_valid = 1'b0;
  logic             ev_ready;
  logic             flush = 1'b0;
  x_idx_t           new_x, neighbor_x;
  y_idx_t           new_y, neighbor_y;
  logic             new_p, neighbor_p;
  logic             pair_valid, done;
  logic [CNT_W-1:0] nb_count;

  int checks = 0;
  int errors = 0;

  event_neighbor_scan #(.DEPTH(DEPTH), .RADIUS(RADIUS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .ev_x(ev_x), .ev_y(ev_y), .ev_p(ev_p),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .flush(flush),
    .new_x(new_x), .new_y(new_y), .new_p(new_p),
    .neighbor_x(neighbor_x), .neighbor_y(neighbor_y), .neighbor_p(neighbor_p),
    .pair_valid(pair_valid), .done(done), .nb_count(nb_count)
  );

  always #5 clk = ~clk;

  // Reference history: plain arrays filled in arrival order, oldest overwritten.
  int m_x[DEPTH], m_y[DEPTH], m_p[DEPTH];
  bit m_v[DEPTH];
  int m_wr;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit same_pairs(input logic [33:0] a[$], input logic [33:0] b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
    m_wr = 0;
  endtask

  task automatic model_scan(input int x, input int y, input int p,
                            output int n, output logic [33:0] q[$]);
    q.delete();
    n = 0;
    for (int i = 0; i < DEPTH; i++)
      if (m_v[i] && iabs(x - m_x[i]) <= RADIUS && iabs(y - m_y[i]) <= RADIUS) begin
        q.push_back({8'(x), 8'(y), 1'(p), 8'(m_x[i]), 8'(m_y[i]), 1'(m_p[i])});
        n++;
      end
  endtask

  task automatic model_insert(input int x, input int y, input int p);
    m_x[m_wr] = x; m_y[m_wr] = y; m_p[m_wr] = p; m_v[m_wr] = 1'b1;
    m_wr = (m_wr + 1) % DEPTH;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstn = 1'b0; ev_valid = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_clear();
  endtask

  // Offers one event and records what the DUT produces; starts/ends at a negedge.
  task automatic do_event(input int x, input int y, input int p,
                          output int n_out, output int done_cyc, output logic rdy_done,
                          output logic [33:0] got[$], output int first_cyc);
    int w;
    got.delete();
    n_out = -1; done_cyc = -1; rdy_done = 1'b0; first_cyc = -1;
    ev_x = x[7:0]; ev_y = y[7:0]; ev_p = p[0]; ev_valid = 1'b1;
    w = 0;
    while (!ev_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) begin
      errors++;
      $display("FAIL accept_timeout: ev_ready=%b required 1 within 100 cycles", ev_ready);
      ev_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 ev_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (pair_valid) begin
        if (first_cyc < 0) first_cyc = c;
        got.push_back({new_x, new_y, new_p, neighbor_x, neighbor_y, neighbor_p});
      end
      if (done) begin
        done_cyc = c; n_out = int'(nb_count); rdy_done = ev_ready;
        break;
      end
    end
  endtask

  task automatic step(input int x, input int y, input int p,
                      output int n, output int en, output int dc, output logic rd,
                      output int fc, output logic [33:0] got[$], output logic [33:0] exp[$]);
    model_scan(x, y, p, en, exp);
    do_event(x, y, p, n, dc, rd, got, fc);
    model_insert(x, y, p);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (ev_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ev_ready); end
    checks++; if (pair_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_flags: pair_valid=%b done=%b want 0 0", pair_valid, done); end
    checks++; if (nb_count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", nb_count); end
    checks++; if ({new_x, new_y, new_p, neighbor_x, neighbor_y, neighbor_p} !== 34'h0) begin errors++; $display("FAIL reset_fields: got %h want 0", {new_x, new_y, new_p, neighbor_x, neighbor_y, neighbor_p}); end
  endtask

  task automatic test_empty();
    int n, en, dc, fc; logic rd; logic [33:0] got[$], exp[$];
    apply_reset();
    step(5, 5, 1, n, en, dc, rd, fc, got, exp);
    checks++; if (n !== en) begin errors++; $display("FAIL empty_count: got %0d want %0d", n, en); end
    checks++; if (dc !== DEPTH + 2) begin errors++; $display("FAIL empty_done_cycle: got %0d want %0d", dc, DEPTH + 2); end
    checks++; if (rd !== 1'b1) begin errors++; $display("FAIL empty_ready_at_done: got %b want 1", rd); end
    checks++; if (got.size() != 0) begin errors++; $display("FAIL empty_pairs: got %0d pairs want 0", got.size()); end
  endtask

  task automatic test_single();
    int n, en, dc, fc; logic rd; logic [33:0] got[$], exp[$];
    apply_reset();
    step(10, 10, 0, n, en, dc, rd, fc, got, exp);
    step(13, 10, 1, n, en, dc, rd, fc, got, exp);
    checks++; if (n !== en) begin errors++; $display("FAIL single_count: got %0d want %0d", n, en); end
    checks++; if (fc !== 2) begin errors++; $display("FAIL single_pair_cycle: got %0d want 2", fc); end
    checks++; if (!same_pairs(got, exp)) begin errors++; $display("FAIL single_pair: got %0d pairs (first %h) want %0d pairs (first %h)", got.size(), (got.size() > 0) ? got[0] : 34'h0, exp.size(), (exp.size() > 0) ? exp[0] : 34'h0); end
    apply_reset();
    step(10, 10, 0, n, en, dc, rd, fc, got, exp);
    step(14, 10, 1, n, en, dc, rd, fc, got, exp);
    checks++; if (n !== en || got.size() != 0) begin errors++; $display("FAIL single_far: count %0d pairs %0d want %0d 0", n, got.size(), en); end
  endtask

  task automatic test_unsigned();
    int n, en, dc, fc; logic rd; logic [33:0] got[$], exp[$];
    apply_reset();
    step(3, 0, 0, n, en, dc, rd, fc, got, exp);
    step(0, 2, 1, n, en, dc, rd, fc, got, exp);
    checks++; if (n !== en || !same_pairs(got, exp)) begin errors++; $display("FAIL unsigned_edge: count %0d pairs %0d want %0d %0d", n, got.size(), en, exp.size()); end
    apply_reset();
    step(0, 0, 0, n, en, dc, rd, fc, got, exp);
    step(255, 0, 1, n, en, dc, rd, fc, got, exp);
    checks++; if (n !== en || got.size() != 0) begin errors++; $display("FAIL unsigned_nowrap: count %0d pairs %0d want %0d 0", n, got.size(), en); end
  endtask

  task automatic test_wrap();
    int n, en, dc, fc, bad; logic rd; logic [33:0] got[$], exp[$];
    apply_reset();
    bad = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      step(i * 14, i * 14, i & 1, n, en, dc, rd, fc, got, exp);
      if (n !== en || dc !== DEPTH + 2) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL wrap_fill: %0d bad events want 0", bad); end
    step(1, 1, 0, n, en, dc, rd, fc, got, exp);
    checks++; if (n !== en) begin errors++; $display("FAIL wrap_overwritten: got %0d want %0d", n, en); end
    step(223, 225, 1, n, en, dc, rd, fc, got, exp);
    checks++; if (n !== en || !same_pairs(got, exp)) begin errors++; $display("FAIL wrap_order: count %0d pairs %0d want %0d %0d", n, got.size(), en, exp.size()); end
  endtask

  task automatic test_flush();
    int n, en, dc, fc, bad; logic rd; logic [33:0] got[$], exp[$];
    apply_reset();
    step(20, 20, 0, n, en, dc, rd, fc, got, exp);
    step(40, 40, 1, n, en, dc, rd, fc, got, exp);
    ev_x = 8'd21; ev_y = 8'd20; ev_p = 1'b1; ev_valid = 1'b1; flush = 1'b1;
    #1;
    checks++; if (ev_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", ev_ready); end
    @(posedge clk);
    #1 flush = 1'b0; ev_valid = 1'b0;
    model_clear();
    bad = 0;
    for (int c = 0; c < DEPTH + 4; c++) begin
      @(negedge clk);
      if (ev_ready !== 1'b1 || pair_valid !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL flush_not_accepted: %0d busy cycles want 0", bad); end
    step(21, 20, 1, n, en, dc, rd, fc, got, exp);
    checks++; if (n !== en || got.size() != 0) begin errors++; $display("FAIL flush_cleared: count %0d pairs %0d want %0d 0", n, got.size(), en); end
  endtask

  task automatic test_back_to_back();
    int n, en, dc, fc, bad_n, bad_p, bad_t; logic rd; logic [33:0] got[$], exp[$];
    apply_reset();
    bad_n = 0; bad_p = 0; bad_t = 0;
    for (int k = 0; k < 60; k++) begin
      step($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 1),
           n, en, dc, rd, fc, got, exp);
      if (n !== en) bad_n++;
      if (!same_pairs(got, exp)) bad_p++;
      if (dc !== DEPTH + 2 || rd !== 1'b1) bad_t++;
    end
    checks++; if (bad_n != 0) begin errors++; $display("FAIL b2b_count: %0d events wrong want 0", bad_n); end
    checks++; if (bad_p != 0) begin errors++; $display("FAIL b2b_pairs: %0d events wrong want 0", bad_p); end
    checks++; if (bad_t != 0) begin errors++; $display("FAIL b2b_timing: %0d events wrong want 0", bad_t); end
  endtask

  task automatic test_reset_midscan();
    int n, en, dc, fc, bad; logic rd; logic pv4; logic [33:0] got[$], exp[$];
    apply_reset();
    step(50, 50, 0, n, en, dc, rd, fc, got, exp);
    step(51, 50, 1, n, en, dc, rd, fc, got, exp);
    step(50, 52, 0, n, en, dc, rd, fc, got, exp);
    step(49, 49, 1, n, en, dc, rd, fc, got, exp);
    ev_x = 8'd50; ev_y = 8'd51; ev_p = 1'b1; ev_valid = 1'b1;
    @(posedge clk);
    #1 ev_valid = 1'b0;
    repeat (4) @(negedge clk);
    pv4 = pair_valid;
    checks++; if (pv4 !== 1'b1) begin errors++; $display("FAIL midscan_pairs_live: got %b want 1", pv4); end
    @(negedge clk);
    rstn = 1'b0;
    bad = 0;
    for (int c = 6; c <= 25; c++) begin
      @(negedge clk);
      if (pair_valid !== 1'b0 || done !== 1'b0) bad++;
      if (c == 7) rstn = 1'b1;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL midscan_drop: %0d cycles with pair_valid/done want 0", bad); end
    model_clear();
    step(50, 51, 0, n, en, dc, rd, fc, got, exp);
    checks++; if (n !== en || got.size() != 0) begin errors++; $display("FAIL midscan_after: count %0d pairs %0d want %0d 0", n, got.size(), en); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    test_reset();
    test_empty();
    test_single();
    test_unsigned();
    test_wrap();
    test_flush();
    test_back_to_back();
    test_reset_midscan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
